// File: rtl/pipeline_pkg.sv
// Shared definitions for the RV64I+Zba five-stage core: datapath widths,
// ResultSrc/ALUControl encodings and the decode-stage control word.
package pipeline_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned REGW = 5;

  // Write-back source select
  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } res_src_e;

  // ALU operation codes, including the Zba shift-and-add group
  typedef enum logic [3:0] {
    ALU_ADD    = 4'b0000,
    ALU_SUB    = 4'b0001,
    ALU_AND    = 4'b0010,
    ALU_OR     = 4'b0011,
    ALU_SH1ADD = 4'b0100,
    ALU_SH2ADD = 4'b0101,
    ALU_SH3ADD = 4'b0110
  } alu_op_e;

  // Control word carried from decode into execute
  typedef struct packed {
    logic     reg_write;
    res_src_e result_src;
    logic     mem_write;
    logic     alu_src;
    alu_op_e  alu_control;
    logic     branch;
    logic     jump;
  } ctrl_t;

endpackage : pipeline_pkg

// File: rtl/id_ex_stage_if.sv
// Decode/execute boundary bundle: decode control word and operands in,
// registered execute-stage view and hazard controls out.
interface id_ex_stage_if #(
  parameter int unsigned XLEN = pipeline_pkg::XLEN,
  parameter int unsigned REGW = pipeline_pkg::REGW
);

  // Decode-stage side
  logic            RegWriteD;
  logic [1:0]      ResultSrcD;
  logic            MemWriteD;
  logic            ALUSrcD;
  logic [3:0]      ALUControlD;
  logic            BranchD;
  logic            JumpD;
  logic [XLEN-1:0] RD1D;
  logic [XLEN-1:0] RD2D;
  logic [XLEN-1:0] PCD;
  logic [XLEN-1:0] PCPlus4D;
  logic [XLEN-1:0] ImmExtD;
  logic [REGW-1:0] Rs1D;
  logic [REGW-1:0] Rs2D;
  logic [REGW-1:0] RdD;
  logic            PCSrcE;

  // Execute-stage side
  logic            RegWriteE;
  logic [1:0]      ResultSrcE;
  logic            MemWriteE;
  logic            ALUSrcE;
  logic [3:0]      ALUControlE;
  logic            BranchE;
  logic            JumpE;
  logic [XLEN-1:0] RD1E;
  logic [XLEN-1:0] RD2E;
  logic [XLEN-1:0] PCE;
  logic [XLEN-1:0] PCPlus4E;
  logic [XLEN-1:0] ImmExtE;
  logic [REGW-1:0] Rs1E;
  logic [REGW-1:0] Rs2E;
  logic [REGW-1:0] RdE;
  logic            ValidE;

  // Hazard controls and performance counters
  logic            StallF;
  logic            StallD;
  logic            FlushD;
  logic [31:0]     BubbleCount;
  logic [31:0]     FlushCount;

  // Driver of the decode side (decoder / testbench)
  modport master (
    output RegWriteD, ResultSrcD, MemWriteD, ALUSrcD, ALUControlD, BranchD, JumpD,
    output RD1D, RD2D, PCD, PCPlus4D, ImmExtD, Rs1D, Rs2D, RdD, PCSrcE,
    input  RegWriteE, ResultSrcE, MemWriteE, ALUSrcE, ALUControlE, BranchE, JumpE,
    input  RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE, ValidE,
    input  StallF, StallD, FlushD, BubbleCount, FlushCount
  );

  // The pipeline register itself
  modport slave (
    input  RegWriteD, ResultSrcD, MemWriteD, ALUSrcD, ALUControlD, BranchD, JumpD,
    input  RD1D, RD2D, PCD, PCPlus4D, ImmExtD, Rs1D, Rs2D, RdD, PCSrcE,
    output RegWriteE, ResultSrcE, MemWriteE, ALUSrcE, ALUControlE, BranchE, JumpE,
    output RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE, ValidE,
    output StallF, StallD, FlushD, BubbleCount, FlushCount
  );

endinterface : id_ex_stage_if

// File: rtl/hazard_detect.sv
// Combinational load-use and redirect hazard unit. The register match is
// deliberately conservative: it ignores whether decode really reads rs1/rs2.
module hazard_detect #(
  parameter int unsigned REGW = pipeline_pkg::REGW
) (
  input  logic                 valid_e_i,
  input  pipeline_pkg::res_src_e result_src_e_i,
  input  logic [REGW-1:0]      rd_e_i,
  input  logic [REGW-1:0]      rs1_d_i,
  input  logic [REGW-1:0]      rs2_d_i,
  input  logic                 pc_src_e_i,
  output logic                 lw_stall_o,
  output logic                 stall_f_o,
  output logic                 stall_d_o,
  output logic                 flush_d_o,
  output logic                 flush_e_o
);

  logic rd_match;

  // Load in E whose destination feeds decode; a redirect overrides the stall
  always_comb begin
    rd_match   = (rd_e_i == rs1_d_i) || (rd_e_i == rs2_d_i);
    lw_stall_o = valid_e_i && (result_src_e_i == pipeline_pkg::RES_MEM) &&
                 (rd_e_i != '0) && rd_match;
    stall_f_o  = lw_stall_o && !pc_src_e_i;
    stall_d_o  = lw_stall_o && !pc_src_e_i;
    flush_d_o  = pc_src_e_i;
    flush_e_o  = lw_stall_o || pc_src_e_i;
  end

endmodule : hazard_detect

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with built-in load-use stall and redirect flush.
// Optional performance counters are built when ID_EX_PERF_EN is defined;
// otherwise BubbleCount/FlushCount are tied to zero.
module id_ex_stage #(
  parameter int unsigned XLEN = pipeline_pkg::XLEN,
  parameter int unsigned REGW = pipeline_pkg::REGW
) (
  input logic          clk,
  input logic          rst_n,
  id_ex_stage_if.slave bus
);

  pipeline_pkg::ctrl_t ctrl_d, ctrl_q;
  logic                valid_d, valid_q;
  logic [XLEN-1:0]     rd1_d, rd1_q;
  logic [XLEN-1:0]     rd2_d, rd2_q;
  logic [XLEN-1:0]     pc_d, pc_q;
  logic [XLEN-1:0]     pc_plus4_d, pc_plus4_q;
  logic [XLEN-1:0]     imm_d, imm_q;
  logic [REGW-1:0]     rs1_d, rs1_q;
  logic [REGW-1:0]     rs2_d, rs2_q;
  logic [REGW-1:0]     rd_d, rd_q;

  logic lw_stall;
  logic stall_f;
  logic stall_d;
  logic flush_d;
  logic flush_e;

  hazard_detect #(
    .REGW (REGW)
  ) u_hazard_detect (
    .valid_e_i      (valid_q),
    .result_src_e_i (ctrl_q.result_src),
    .rd_e_i         (rd_q),
    .rs1_d_i        (bus.Rs1D),
    .rs2_d_i        (bus.Rs2D),
    .pc_src_e_i     (bus.PCSrcE),
    .lw_stall_o     (lw_stall),
    .stall_f_o      (stall_f),
    .stall_d_o      (stall_d),
    .flush_d_o      (flush_d),
    .flush_e_o      (flush_e)
  );

  // Next E contents: a fully zeroed bubble on flush, else capture decode
  always_comb begin
    ctrl_d     = '0;
    valid_d    = 1'b0;
    rd1_d      = '0;
    rd2_d      = '0;
    pc_d       = '0;
    pc_plus4_d = '0;
    imm_d      = '0;
    rs1_d      = '0;
    rs2_d      = '0;
    rd_d       = '0;
    if (!flush_e) begin
      ctrl_d.reg_write   = bus.RegWriteD;
      ctrl_d.result_src  = pipeline_pkg::res_src_e'(bus.ResultSrcD);
      ctrl_d.mem_write   = bus.MemWriteD;
      ctrl_d.alu_src     = bus.ALUSrcD;
      ctrl_d.alu_control = pipeline_pkg::alu_op_e'(bus.ALUControlD);
      ctrl_d.branch      = bus.BranchD;
      ctrl_d.jump        = bus.JumpD;
      valid_d            = 1'b1;
      rd1_d              = bus.RD1D;
      rd2_d              = bus.RD2D;
      pc_d               = bus.PCD;
      pc_plus4_d         = bus.PCPlus4D;
      imm_d              = bus.ImmExtD;
      rs1_d              = bus.Rs1D;
      rs2_d              = bus.Rs2D;
      rd_d               = bus.RdD;
    end
  end

  // E-stage registers; never stalled, only bubbled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q     <= '0;
      valid_q    <= 1'b0;
      rd1_q      <= '0;
      rd2_q      <= '0;
      pc_q       <= '0;
      pc_plus4_q <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      valid_q    <= valid_d;
      rd1_q      <= rd1_d;
      rd2_q      <= rd2_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      imm_q      <= imm_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
    end
  end

  assign bus.RegWriteE   = ctrl_q.reg_write;
  assign bus.ResultSrcE  = ctrl_q.result_src;
  assign bus.MemWriteE   = ctrl_q.mem_write;
  assign bus.ALUSrcE     = ctrl_q.alu_src;
  assign bus.ALUControlE = ctrl_q.alu_control;
  assign bus.BranchE     = ctrl_q.branch;
  assign bus.JumpE       = ctrl_q.jump;
  assign bus.RD1E        = rd1_q;
  assign bus.RD2E        = rd2_q;
  assign bus.PCE         = pc_q;
  assign bus.PCPlus4E    = pc_plus4_q;
  assign bus.ImmExtE     = imm_q;
  assign bus.Rs1E        = rs1_q;
  assign bus.Rs2E        = rs2_q;
  assign bus.RdE         = rd_q;
  assign bus.ValidE      = valid_q;
  assign bus.StallF      = stall_f;
  assign bus.StallD      = stall_d;
  assign bus.FlushD      = flush_d;

`ifdef ID_EX_PERF_EN
  logic [31:0] bubble_cnt_d, bubble_cnt_q;
  logic [31:0] flush_cnt_d, flush_cnt_q;

  // Count inserted load-use bubbles and redirects; both wrap naturally
  always_comb begin
    bubble_cnt_d = bubble_cnt_q + {31'd0, lw_stall & ~bus.PCSrcE};
    flush_cnt_d  = flush_cnt_q + {31'd0, bus.PCSrcE};
  end

  // Performance counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign bus.BubbleCount = bubble_cnt_q;
  assign bus.FlushCount  = flush_cnt_q;
`else
  logic unused_lw_stall;
  assign unused_lw_stall = lw_stall;
  assign bus.BubbleCount = '0;
  assign bus.FlushCount  = '0;
`endif

endmodule : id_ex_stage

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline register for the RV64I+Zba five-stage core, with load-use hazard detection and control-hazard flushing built in. It captures the decode-stage control word from the instruction decoder, together with the register operands, immediate and PC values, and presents them to the execute stage one cycle later. It generates the fetch/decode stall and flush signals that keep the pipeline correct without forwarding of load data.

## Interface
Parameters:
- XLEN, 64, datapath width
- REGW, 5, register-index width

Ports:
- clk  in  1  core clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- RegWriteD  in  1  decode control word: register write
- ResultSrcD  in  2  decode control word: 00 ALU, 01 memory, 10 PC+4
- MemWriteD  in  1  decode control word: memory write
- ALUSrcD  in  1  decode control word: ALU operand B is the immediate
- ALUControlD  in  4  decode control word: ALU operation code
- BranchD  in  1  decode control word: branch
- JumpD  in  1  decode control word: jump
- RD1D, RD2D  in  XLEN  register-file read data
- PCD, PCPlus4D, ImmExtD  in  XLEN  decode PC, PC+4 and extended immediate
- Rs1D, Rs2D, RdD  in  REGW  register indices
- PCSrcE  in  1  execute-stage redirect (taken branch or jump)
- RegWriteE, ResultSrcE, MemWriteE, ALUSrcE, ALUControlE, BranchE, JumpE  out  as D  registered control word
- RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE  out  as D  registered data
- ValidE  out  1  execute slot holds a real instruction
- StallF, StallD  out  1  hold the PC and IF/ID registers
- FlushD  out  1  clear the IF/ID register
- BubbleCount, FlushCount  out  32  performance counters (see Configuration)

## Operation
- lwStall = ValidE & (ResultSrcE == 01) & (RdE != 0) & ((RdE == Rs1D) | (RdE == Rs2D)).
- The comparison is conservative: it ignores whether the decode instruction actually reads rs1 or rs2. Spurious stalls (for example on jal) are allowed and expected.
- StallF = StallD = lwStall & ~PCSrcE.
- FlushD = PCSrcE.
- FlushE = lwStall | PCSrcE. This is an internal signal.
- Each rising edge, priority order:
  - FlushE: load a bubble. All control outputs go to 0, ValidE goes to 0, RdE goes to 0. Data registers also clear to 0.
  - Otherwise: capture all D inputs and set ValidE to 1.
- The E stage itself is never stalled.
- A bubble has RegWriteE = 0 and MemWriteE = 0, so it can have no architectural effect.
- PCSrcE and lwStall cannot both be true for a legal E instruction, since a load never redirects. If both are asserted, flush has priority: StallF and StallD are 0 and a bubble is inserted.

## Timing
- Reset (asynchronous assert): every E output is 0, ValidE = 0, and the counters are 0. Because ValidE = 0, StallF and StallD are 0 immediately.
- Release of reset is sampled on the first rising edge after rst_n goes high.
- Latency from D inputs to E outputs: 1 cycle.
- StallF, StallD and FlushD are combinational from the E registers and the current D inputs. They are valid in the same cycle.
- A load-use hazard costs exactly one bubble:
  - Cycle n: the load is in E and the dependent instruction is in D, so the stall is asserted.
  - Cycle n+1: the bubble is in E and the dependent instruction is still in D, so no stall.
- A redirect costs two squashed slots: D is flushed and E receives a bubble on the same edge.
- Reset asserted mid-stall: everything clears, and the stall deasserts asynchronously with ValidE.

## Configuration
- ID_EX_PERF_EN defined:
  - BubbleCount increments on every edge where lwStall & ~PCSrcE.
  - FlushCount increments on every edge where PCSrcE.
  - Both counters wrap modulo 2^32 and reset to 0.
- ID_EX_PERF_EN undefined: no counter flops exist, and both ports are tied to 0.

## Structure
- The shared package pipeline_pkg holds:
  - XLEN and REGW
  - the ResultSrc encodings (RES_ALU, RES_MEM, RES_PC4)
  - the ALUControl encodings (ADD 0000, SUB 0001, AND 0010, OR 0011, SH1ADD 0100, SH2ADD 0101, SH3ADD 0110)
  - a packed struct ctrl_t for the control word
- The E registers are stored as a ctrl_t plus data fields.
- One sub-module, hazard_detect, is purely combinational. It produces lwStall, StallF, StallD, FlushD and FlushE.

## Test plan
- Reset applied: all outputs read 0 and ValidE = 0. Release reset and drive an addi with RdD = 5: the next cycle shows RegWriteE = 1, RdE = 5, ValidE = 1.
- ld x5 in E with add x6,x5,x7 in D: StallF = StallD = 1. The next edge leaves RegWriteE = 0 and ValidE = 0, and the stall then drops. BubbleCount = 1 if ID_EX_PERF_EN is defined.
- ld x0 in E with Rs1D = 0: no stall, and the D instruction is captured normally.
- beq in E with PCSrcE = 1: FlushD = 1, StallD = 0, and the next edge inserts a bubble. FlushCount = 1 if ID_EX_PERF_EN is defined.
- PCSrcE and a forced load-match asserted together: FlushD = 1, StallF = 0, and a bubble is inserted.
- rst_n asserted while a stall is active: outputs clear asynchronously before the next edge and StallD returns to 0.
